// File: rtl/rle_pkg.sv
// Shared types and default parameters for the run-length encoder slice.
package rle_pkg;

    localparam int DATA_W_DEF = 3;
    localparam int CNT_W_DEF  = 8;
    localparam int DEPTH_DEF  = 4;

    // Run tracker: IDLE has no open run; RUN holds cur_sym/cur_len.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One encoded record at the default widths: symbol plus run length.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] sym;
        logic [CNT_W_DEF-1:0]  len;
    } rec_t;

endpackage

// File: rtl/rle_fifo.sv
// First-word fall-through record FIFO. The head entry is presented straight
// from the storage array, so rdata never depends combinationally on wdata.
// A push while full is accepted only when a pop frees a slot in the same
// cycle; otherwise the caller sees full and decides what to do.
module rle_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally; the extra count bit tells full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/moore_rle.sv
// Run-length encoder for the Moore FSM symbol stream. Consecutive identical
// symbols collapse into (symbol, length) records; a closed run is staged in
// one register and written into the record FIFO on the following edge, so
// nothing on out_* depends combinationally on in_*.
//
// Output handshake: out_valid means the FIFO head (out_sym, out_len) is a
// real record; the record is consumed on a rising edge where out_valid and
// out_ready are both high. out_valid never waits on out_ready, and the head
// stays stable until it is consumed. out_ready while out_valid is low is
// ignored.
module moore_rle
    import rle_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_sym,
    output logic [CNT_W-1:0]  out_len,
    input  logic              out_ready,
    output logic              overflow,
    output logic              state_dbg
);

    localparam logic [CNT_W-1:0] MAX_LEN = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t            state, state_nx;
    logic [DATA_W-1:0] cur_sym, cur_sym_nx;
    logic [CNT_W-1:0]  cur_len, cur_len_nx;
    logic              emit_nx;
    logic [DATA_W-1:0] emit_sym_nx;
    logic [CNT_W-1:0]  emit_len_nx;

    logic              emit_v;
    logic [DATA_W-1:0] emit_sym;
    logic [CNT_W-1:0]  emit_len;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W+CNT_W-1:0] fifo_rdata;

    assign state_dbg = state;

    // Tracker state and the staged record register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cur_sym  <= '0;
            cur_len  <= '0;
            emit_v   <= 1'b0;
            emit_sym <= '0;
            emit_len <= '0;
        end else begin
            state    <= state_nx;
            cur_sym  <= cur_sym_nx;
            cur_len  <= cur_len_nx;
            emit_v   <= emit_nx;
            emit_sym <= emit_sym_nx;
            emit_len <= emit_len_nx;
        end
    end

    // Next run state and the record (if any) closed on this edge.
    always_comb begin
        state_nx    = state;
        cur_sym_nx  = cur_sym;
        cur_len_nx  = cur_len;
        emit_nx     = 1'b0;
        emit_sym_nx = cur_sym;
        emit_len_nx = cur_len;
        case (state)
            IDLE: begin
                // A flush with no open run has nothing to close.
                if (in_valid) begin
                    state_nx   = RUN;
                    cur_sym_nx = in_data;
                    cur_len_nx = ONE;
                end
            end
            RUN: begin
                if (flush) begin
                    // Flush closes the run even if in_data matches it.
                    emit_nx = 1'b1;
                    if (in_valid) begin
                        cur_sym_nx = in_data;
                        cur_len_nx = ONE;
                    end else begin
                        state_nx   = IDLE;
                        cur_len_nx = '0;
                    end
                end else if (in_valid) begin
                    if (in_data == cur_sym) begin
                        // Saturation is checked before increment: no wrap.
                        if (cur_len == MAX_LEN) begin
                            emit_nx    = 1'b1;
                            cur_len_nx = ONE;
                        end else begin
                            cur_len_nx = cur_len + ONE;
                        end
                    end else begin
                        emit_nx    = 1'b1;
                        cur_sym_nx = in_data;
                        cur_len_nx = ONE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign fifo_pop  = out_ready & ~fifo_empty;
    assign out_valid = ~fifo_empty;
    assign {out_sym, out_len} = fifo_rdata;

    rle_fifo #(
        .W     (DATA_W + CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (emit_v),
        .wdata ({emit_sym, emit_len}),
        .pop   (out_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sticky drop flag: a staged record met a full FIFO with no pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (emit_v & fifo_full & ~fifo_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_moore_rle.sv
// Bench for moore_rle: directed scenarios plus randomized traffic, checked
// against a run-length reference model and a record scoreboard.
module tb_moore_rle;

    localparam int DW     = 3;
    localparam int CW     = 8;
    localparam int DEPTH  = 4;
    localparam int RW     = DW + CW;
    localparam int MAXLEN = 255;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic [DW-1:0] out_sym;
    logic [CW-1:0] out_len;
    logic          out_ready;
    logic          overflow;
    logic          state_dbg;

    int n_tests;
    int n_fail;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];

    // Reference model: open run, one staged record, FIFO occupancy.
    bit            m_open;
    int            m_sym;
    int            m_len;
    bit            m_pend_v;
    logic [RW-1:0] m_pend;
    int            m_cnt;
    bit            m_ovf;

    moore_rle #(.DATA_W(DW), .CNT_W(CW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_sym   (out_sym),
        .out_len   (out_len),
        .out_ready (out_ready),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk(input int s, input int l);
        logic [DW-1:0] s_b;
        logic [CW-1:0] l_b;
        s_b = DW'(s);
        l_b = CW'(l);
        return {s_b, l_b};
    endfunction

    // Scoreboard monitor: every record the DUT hands over is compared.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            got_q.push_back({out_sym, out_len});
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL record: got sym=%0d len=%0d required none", out_sym, out_len);
            end else begin
                logic [RW-1:0] e;
                e = exp_q.pop_front();
                if ({out_sym, out_len} !== e) begin
                    n_fail++;
                    $display("FAIL record: got sym=%0d len=%0d required sym=%0d len=%0d",
                             out_sym, out_len, e[RW-1:CW], e[CW-1:0]);
                end
            end
        end
    end

    function automatic void model_emit(input int s, input int l);
        m_pend_v = 1'b1;
        m_pend   = mk(s, l);
    endfunction

    // One rising edge of the reference model for the given inputs.
    function automatic void model_edge(input bit v, input int d, input bit f, input bit r);
        bit pop;
        pop = r && (m_cnt > 0);
        if (m_pend_v) begin
            if (m_cnt < DEPTH || pop) begin
                exp_q.push_back(m_pend);
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (pop) m_cnt--;
        m_pend_v = 1'b0;
        if (f && m_open) begin
            model_emit(m_sym, m_len);
            if (v) begin
                m_sym = d;
                m_len = 1;
            end else begin
                m_open = 1'b0;
            end
        end else if (v) begin
            if (!m_open) begin
                m_open = 1'b1;
                m_sym  = d;
                m_len  = 1;
            end else if (d == m_sym) begin
                if (m_len == MAXLEN) begin
                    model_emit(m_sym, MAXLEN);
                    m_len = 1;
                end else begin
                    m_len++;
                end
            end else begin
                model_emit(m_sym, m_len);
                m_sym = d;
                m_len = 1;
            end
        end
    endfunction

    // Driver: apply inputs for one edge, advance model, check flags after.
    task automatic step(input bit v, input int d, input bit f, input bit r);
        in_valid  = v;
        in_data   = DW'(d);
        flush     = f;
        out_ready = r;
        model_edge(v, d, f, r);
        @(posedge clk);
        #1;
        check("out_valid", out_valid, int'(m_cnt > 0));
        check("overflow", overflow, int'(m_ovf));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1);
    endtask

    task automatic do_reset();
        #2;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sym", out_sym, 0);
        check("rst_out_len", out_len, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", state_dbg, 0);
        exp_q.delete();
        got_q.delete();
        m_open   = 1'b0;
        m_sym    = 0;
        m_len    = 0;
        m_pend_v = 1'b0;
        m_cnt    = 0;
        m_ovf    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_got(input string name, input int idx, input int s, input int l);
        if (idx < got_q.size()) begin
            check(name, int'(got_q[idx]), int'(mk(s, l)));
        end else begin
            check({name, "_present"}, got_q.size(), idx + 1);
        end
    endtask

    initial begin
        int last_d;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;

        // Basic runs: 5,5,5,6,6 then flush.
        do_reset();
        step(1, 5, 0, 1); step(1, 5, 0, 1); step(1, 5, 0, 1);
        step(1, 6, 0, 1); step(1, 6, 0, 1); step(0, 0, 1, 1);
        drain(4);
        check("basic_count", got_q.size(), 2);
        check_got("basic_r0", 0, 5, 3);
        check_got("basic_r1", 1, 6, 2);

        // Saturation: 300 sevens split into 255 + 45.
        do_reset();
        for (int i = 0; i < 300; i++) step(1, 7, 0, 1);
        step(0, 0, 1, 1);
        drain(4);
        check("sat_count", got_q.size(), 2);
        check_got("sat_r0", 0, 7, 255);
        check_got("sat_r1", 1, 7, 45);

        // Overflow: consumer stalled, six records against a depth of four.
        do_reset();
        for (int i = 1; i <= 6; i++) step(1, i, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("ovf_flag", overflow, 1);
        drain(8);
        check("ovf_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) check_got("ovf_rec", i, i + 1, 1);
        check("ovf_sticky", overflow, 1);

        // Full FIFO: push lands on the same edge as a pop.
        do_reset();
        for (int i = 1; i <= 5; i++) step(1, i, 0, 0);
        step(1, 6, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("fullpop_ovf", overflow, 0);
        drain(8);
        check("fullpop_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) check_got("fullpop_rec", i, i + 1, 1);

        // Gaps do not break a run; flush with in_valid reopens the run.
        do_reset();
        step(1, 3, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
        step(1, 3, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
        step(1, 3, 1, 1);
        check("gap_open", state_dbg, 1);
        step(0, 0, 1, 1);
        check("gap_closed", state_dbg, 0);
        drain(4);
        check("gap_count", got_q.size(), 2);
        check_got("gap_r0", 0, 3, 2);
        check_got("gap_r1", 1, 3, 1);

        // Reset mid-run with a buffered record discards everything.
        do_reset();
        step(1, 7, 0, 0); step(0, 0, 1, 0);
        step(1, 5, 0, 0); step(1, 5, 0, 0);
        check("prerst_valid", out_valid, 1);
        do_reset();
        step(1, 2, 0, 1); step(0, 0, 1, 1);
        drain(4);
        check("postrst_count", got_q.size(), 1);
        check_got("postrst_r0", 0, 2, 1);

        // Randomized traffic with mixed back-pressure.
        do_reset();
        last_d = 0;
        for (int i = 0; i < 3000; i++) begin
            bit v, f, r;
            int d;
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 9) < 7) ? last_d : int'($urandom_range(0, 7));
            last_d = d;
            f = ($urandom_range(0, 19) == 0);
            r = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step(v, d, f, r);
        end
        step(0, 0, 1, 1);
        drain(8);
        check("rand_leftover", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/moore_rle.md
# moore_rle

Run-length encoder that sits directly downstream of the Moore FSM stage and consumes its 3-bit `out` symbol stream. It compresses consecutive identical symbols into (symbol, length) records and buffers them in a small FIFO. A consumer drains the FIFO with a valid/ready handshake. Any record that cannot be stored is dropped and flagged.

## Interface
- `DATA_W`, default 3: symbol width; matches the upstream FSM output.
- `CNT_W`, default 8: run-length counter width; maximum length is 2^CNT_W−1.
- `DEPTH`, default 4: record FIFO depth; must be a power of two.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `in_valid`  in  1  `in_data` holds a sample this cycle.
- `in_data`  in  DATA_W  symbol from the upstream FSM `out`.
- `flush`  in  1  close the current run and emit it.
- `out_valid`  out  1  FIFO head record is available.
- `out_sym`  out  DATA_W  head record symbol.
- `out_len`  out  CNT_W  head record run length, range 1..2^CNT_W−1.
- `out_ready`  in  1  consumer accepts the head record.
- `overflow`  out  1  sticky flag; a record was dropped.

## Operation
- Run tracker states:
  - IDLE: no open run.
  - RUN: open run with `cur_sym` and `cur_len`.
- Tracker transitions, evaluated on each rising edge:
  - IDLE, `in_valid`: go to RUN with `cur_sym=in_data`, `cur_len=1`.
  - RUN, `in_valid`, `in_data==cur_sym`, `cur_len<max`: increment `cur_len`.
  - RUN, `in_valid`, `in_data==cur_sym`, `cur_len==max`: emit (`cur_sym`, max); new run of the same symbol with `cur_len=1`.
  - RUN, `in_valid`, `in_data!=cur_sym`: emit (`cur_sym`, `cur_len`); new run with `cur_sym=in_data`, `cur_len=1`.
  - RUN, `flush`, no `in_valid`: emit current run; go to IDLE.
  - RUN, `flush` with `in_valid`: emit current run; new run with `in_data`, `cur_len=1`, regardless of symbol equality.
  - IDLE, `flush`: no effect.
  - `in_valid` low and `flush` low: hold state. Gaps never break a run.
- Emit writes one record per cycle into the FIFO. At most one emit can occur per cycle.
- FIFO behaviour:
  - First-word fall-through: `out_sym`/`out_len` show the head whenever `out_valid=1`.
  - A pop occurs when `out_valid & out_ready`.
  - When full, a push is accepted only if a pop occurs in the same cycle; otherwise the record is dropped and `overflow` is set.
  - Push and pop in the same cycle while not empty leave the count unchanged.
  - Pop while empty is ignored.
- `overflow` clears only on reset.
- `out_sym`/`out_len` are don't-care while `out_valid=0`, but are driven from registered storage with no combinational path from the inputs.

## Timing
- Reset values: state IDLE, `cur_len=0`, FIFO empty, `out_valid=0`, `out_sym=0`, `out_len=0`, `overflow=0`.
- Reset asserted mid-run or mid-drain: the open run and all buffered records are discarded immediately.
- Latency: an emit caused by the edge at cycle N makes the record visible with `out_valid=1` after edge N+1 if the FIFO was empty. No combinational path from `in_*` to `out_*`.
- Throughput: one sample per cycle in; one record per cycle out.
- Length arithmetic is unsigned CNT_W bits; the saturation check precedes increment, so no wrap occurs.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by a log2(DEPTH)+1-bit count.

## Structure
- Shared package `rle_pkg`:
  - `state_t` enum (IDLE, RUN).
  - Record struct {sym, len}.
  - Defaults for DATA_W/CNT_W/DEPTH.
- One sub-module: `rle_fifo`, a parameterized synchronous FWFT FIFO with push/pop, full/empty and count.
- The top level holds the run tracker and the overflow flag.

## Test plan
- `in_data` 5,5,5,6,6 with `in_valid=1`, then `flush`, `out_ready=1`: records (5,3), then (6,2); `overflow=0`.
- 300 consecutive samples of 7 (CNT_W=8), then `flush`: records (7,255), then (7,45).
- `out_ready=0`; stream 1,2,3,4,5,6 then `flush`: 4 records stored, (1,1)…(4,1); `overflow=1` after the fifth emit; later draining yields only those 4.
- FIFO full; a run ends in the same cycle that `out_ready=1` pops the head: push accepted, count stays 4, `overflow` stays 0.
- 3,3 with `in_valid` gaps of 2 idle cycles, then `flush` and simultaneous `in_valid` with 3: record (3,2), new run (3,1) open.
- Reset asserted after 5,5 plus one buffered record: `out_valid=0` immediately; after release, the stream 2 then `flush` yields (2,1) only.
